hit_trig_gen: RTL and testbench

HIT_TRIG_GEN -- requirements
Module: hit_trig_gen

---
 rtl/hit_trig_gen_if.sv | 33 +++
 rtl/hit_trig_gen.sv | 166 ++++++++++++++++
 tb/tb_hit_trig_gen.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_trig_gen_if.sv
// Control, configuration and status bundle for hit_trig_gen.
// The master drives START/ABORT and the configuration; the slave returns the registered status and the hit drive.
interface hit_trig_gen_if #(
  parameter int N_PIX = 4096,
  parameter int CNT_W = 16
);
  // Handshake: START is a one-cycle request. It is accepted only in IDLE with REPEAT != 0.
  // BUSY is high from the cycle after acceptance until the cycle after DONE, or until ABORT/reset.
  // There is no backpressure; a request made while BUSY is dropped.
  logic             START;
  logic             ABORT;
  logic [N_PIX-1:0] PIX_MASK;
  logic [CNT_W-1:0] HIT_WIDTH;
  logic [CNT_W-1:0] TRIG_DELAY;
  logic [CNT_W-1:0] GAP_LEN;
  logic [CNT_W-1:0] REPEAT;
  logic [N_PIX-1:0] HIT;
  logic             TRIGGER;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] TRIG_CNT;
  logic [2:0]       DBG_STATE;

  modport master (
    output START, ABORT, PIX_MASK, HIT_WIDTH, TRIG_DELAY, GAP_LEN, REPEAT,
    input  HIT, TRIGGER, BUSY, DONE, TRIG_CNT, DBG_STATE
  );

  modport slave (
    input  START, ABORT, PIX_MASK, HIT_WIDTH, TRIG_DELAY, GAP_LEN, REPEAT,
    output HIT, TRIGGER, BUSY, DONE, TRIG_CNT, DBG_STATE
  );
endinterface

// File: rtl/hit_trig_gen.sv
// Pixel hit / trigger sequence generator: hit pulse, delay, trigger, gap, repeated REPEAT times.
// Optional macro HIT_GEN_ROTATE_EN rotates the latched pixel mask left by one position after every trigger.
module hit_trig_gen #(
  parameter int N_PIX = 4096,
  parameter int CNT_W = 16
) (
  input  logic          BUS_CLK,
  input  logic          BUS_RST,
  hit_trig_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIT   = 3'd1,
    S_DELAY = 3'd2,
    S_TRIG  = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           r_state;
  logic [N_PIX-1:0] r_mask;
  logic [CNT_W-1:0] r_hit_width;
  logic [CNT_W-1:0] r_trig_delay;
  logic [CNT_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_iter_left;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_trig_cnt;
  logic [N_PIX-1:0] r_hit;
  logic             r_trigger;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [N_PIX-1:0] w_mask_nxt;
  logic [CNT_W-1:0] w_hit_width_nxt;
  logic [CNT_W-1:0] w_trig_delay_nxt;
  logic [CNT_W-1:0] w_gap_len_nxt;
  logic [CNT_W-1:0] w_iter_left_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_trig_cnt_nxt;
  logic [CNT_W-1:0] w_hit_last_cnt;
  logic             w_more_iter;

  // A zero hit width still produces a one-cycle pulse.
  assign w_hit_last_cnt = (r_hit_width == '0) ? '0 : r_hit_width - CNT_W'(1);
  assign w_more_iter    = (r_iter_left > CNT_W'(1));

  always_comb begin
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_hit_width_nxt  = r_hit_width;
    w_trig_delay_nxt = r_trig_delay;
    w_gap_len_nxt    = r_gap_len;
    w_iter_left_nxt  = r_iter_left;
    w_cnt_nxt        = r_cnt;
    w_trig_cnt_nxt   = r_trig_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (bus.START && (bus.REPEAT != '0)) begin
          w_mask_nxt       = bus.PIX_MASK;
          w_hit_width_nxt  = bus.HIT_WIDTH;
          w_trig_delay_nxt = bus.TRIG_DELAY;
          w_gap_len_nxt    = bus.GAP_LEN;
          w_iter_left_nxt  = bus.REPEAT;
          w_cnt_nxt        = '0;
          w_trig_cnt_nxt   = '0;
          w_state_nxt      = S_HIT;
        end
      end
      S_HIT: begin
        if (r_cnt == w_hit_last_cnt) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_trig_delay != '0) ? S_DELAY : S_TRIG;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (r_cnt == r_trig_delay - CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_TRIG;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_TRIG: begin
        w_iter_left_nxt = r_iter_left - CNT_W'(1);
        w_cnt_nxt       = '0;
`ifdef HIT_GEN_ROTATE_EN
        w_mask_nxt = {r_mask[N_PIX-2:0], r_mask[N_PIX-1]};
`endif
        // The gap separates iterations; the final trigger goes straight to FIN.
        if (w_more_iter) begin
          w_state_nxt = (r_gap_len != '0) ? S_GAP : S_HIT;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        if (r_cnt == r_gap_len - CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_TRIG) begin
      w_trig_cnt_nxt = r_trig_cnt + CNT_W'(1);
    end

    if ((r_state != S_IDLE) && bus.ABORT) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_trig_cnt_nxt = r_trig_cnt;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_hit_width  <= '0;
      r_trig_delay <= '0;
      r_gap_len    <= '0;
      r_iter_left  <= '0;
      r_cnt        <= '0;
      r_trig_cnt   <= '0;
      r_hit        <= '0;
      r_trigger    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_hit_width  <= w_hit_width_nxt;
      r_trig_delay <= w_trig_delay_nxt;
      r_gap_len    <= w_gap_len_nxt;
      r_iter_left  <= w_iter_left_nxt;
      r_cnt        <= w_cnt_nxt;
      r_trig_cnt   <= w_trig_cnt_nxt;
      r_hit        <= (w_state_nxt == S_HIT) ? w_mask_nxt : '0;
      r_trigger    <= (w_state_nxt == S_TRIG);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_FIN);
    end
  end

  assign bus.HIT       = r_hit;
  assign bus.TRIGGER   = r_trigger;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.TRIG_CNT  = r_trig_cnt;
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_hit_trig_gen.sv
// Self-checking bench for hit_trig_gen: per-cycle expected output words are queued when a run is started
// and compared at the falling edge; HIT_GEN_ROTATE_EN selects the rotated-mask expectation.
module tb_hit_trig_gen;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam int EW = N + 3 + CW;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w;
  logic [EW-1:0] obs_w;
  logic [CW-1:0] model_cnt;

  hit_trig_gen_if #(.N_PIX(N), .CNT_W(CW)) bus ();

  hit_trig_gen #(.N_PIX(N), .CNT_W(CW)) u_dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pack(input logic [N-1:0] m, input logic t, input logic b,
                                         input logic d, input logic [CW-1:0] c);
    return {m, t, b, d, c};
  endfunction

  function automatic logic [EW-1:0] observe();
    return {bus.HIT, bus.TRIGGER, bus.BUSY, bus.DONE, bus.TRIG_CNT};
  endfunction

  // Expected timeline of a full run: hit, delay, trigger, gap between iterations, FIN, one idle cycle.
  task automatic push_run(input logic [N-1:0] mask, input int hw, input int dly, input int gap, input int rep);
    logic [N-1:0]  m;
    logic [CW-1:0] c;
    m = mask;
    c = '0;
    for (int it = 0; it < rep; it++) begin
      for (int k = 0; k < ((hw == 0) ? 1 : hw); k++) exp_q.push_back(pack(m, 1'b0, 1'b1, 1'b0, c));
      for (int k = 0; k < dly; k++) exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, c));
      c = c + CW'(1);
      exp_q.push_back(pack('0, 1'b1, 1'b1, 1'b0, c));
      if (it < rep - 1) begin
        for (int k = 0; k < gap; k++) exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, c));
      end
`ifdef HIT_GEN_ROTATE_EN
      m = {m[N-2:0], m[N-1]};
`endif
    end
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b1, c));
    exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, c));
    model_cnt = c;
  endtask

  // Driver: presents configuration with a one-cycle START; returns just after the accepting edge.
  task automatic start_run(input logic [N-1:0] mask, input int hw, input int dly, input int gap, input int rep);
    @(negedge clk);
    bus.PIX_MASK   = mask;
    bus.HIT_WIDTH  = CW'(hw);
    bus.TRIG_DELAY = CW'(dly);
    bus.GAP_LEN    = CW'(gap);
    bus.REPEAT     = CW'(rep);
    bus.START      = 1'b1;
    @(posedge clk);
    #1 bus.START = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    obs_w = observe();
    if (obs_w !== pack('0, 1'b0, 1'b0, 1'b0, '0)) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", obs_w, pack('0, 1'b0, 1'b0, 1'b0, '0));
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    obs_w = observe();
    if (obs_w !== pack('0, 1'b0, 1'b0, 1'b0, '0)) begin
      n_err++;
      $display("FAIL reset_release: got %h expected %h", obs_w, pack('0, 1'b0, 1'b0, 1'b0, '0));
    end
  endtask

  task automatic test_basic();
    push_run(16'h0020, 3, 2, 4, 1);
    start_run(16'h0020, 3, 2, 4, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL basic cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_min_timing();
    push_run(16'h8421, 0, 0, 0, 3);
    start_run(16'h8421, 0, 0, 0, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL min_timing cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_repeat_zero();
    for (int k = 0; k < 4; k++) exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, model_cnt));
    start_run(16'hFFFF, 2, 1, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL repeat_zero cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_start_ignored();
    push_run(16'h0020, 3, 2, 4, 2);
    start_run(16'h0020, 3, 2, 4, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL start_ignored cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
      if (i == 3 || i == 8) begin
        bus.START     = 1'b1;
        bus.REPEAT    = CW'(5);
        bus.HIT_WIDTH = CW'(1);
        bus.PIX_MASK  = 16'h0F0F;
      end else begin
        bus.START = 1'b0;
      end
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 3; k++) exp_q.push_back(pack(16'h0020, 1'b0, 1'b1, 1'b0, '0));
    for (int k = 0; k < 2; k++) exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, '0));
    start_run(16'h0020, 3, 2, 4, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL abort_hit cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
      bus.ABORT = (i == 2);
    end
    // Abort after one trigger: the counter keeps its value.
    exp_q.push_back(pack(16'h0003, 1'b0, 1'b1, 1'b0, CW'(0)));
    exp_q.push_back(pack('0, 1'b1, 1'b1, 1'b0, CW'(1)));
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, CW'(1)));
    for (int k = 0; k < 3; k++) exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, CW'(1)));
    start_run(16'h0003, 1, 0, 2, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL abort_gap cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
      bus.ABORT = (i == 2 || i == 4);
    end
    bus.ABORT = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(pack(16'h0003, 1'b0, 1'b1, 1'b0, CW'(0)));
    exp_q.push_back(pack('0, 1'b1, 1'b1, 1'b0, CW'(1)));
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, CW'(1)));
    for (int k = 0; k < 3; k++) exp_q.push_back(pack('0, 1'b0, 1'b0, 1'b0, CW'(0)));
    start_run(16'h0003, 1, 0, 2, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
      rst = (i == 2);
      bus.ABORT = (i == 2);
    end
    rst = 1'b0;
    bus.ABORT = 1'b0;
  endtask

  task automatic test_abort_start_same();
    push_run(16'h1234, 2, 1, 1, 2);
    bus.ABORT = 1'b1;
    start_run(16'h1234, 2, 1, 1, 2);
    bus.ABORT = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL abort_start_same cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_mask_latch();
    push_run(16'h8000, 2, 1, 1, 2);
    start_run(16'h8000, 2, 1, 1, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      obs_w = observe();
      n_vec++;
      if (obs_w !== exp_w) begin
        n_err++;
        $display("FAIL mask_latch cyc%0d: got %h expected %h", i, obs_w, exp_w);
      end
      if (i == 1) begin
        bus.PIX_MASK   = 16'h00F0;
        bus.HIT_WIDTH  = CW'($urandom_range(1, 9));
        bus.TRIG_DELAY = CW'($urandom_range(2, 9));
        bus.GAP_LEN    = CW'($urandom_range(2, 9));
        bus.REPEAT     = CW'($urandom_range(3, 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      push_run(16'h0001 << r, 0, 0, 0, 15);
      start_run(16'h0001 << r, 0, 0, 0, 15);
      for (int i = 0; exp_q.size() > 0; i++) begin
        @(negedge clk);
        exp_w = exp_q.pop_front();
        obs_w = observe();
        n_vec++;
        if (obs_w !== exp_w) begin
          n_err++;
          $display("FAIL back_to_back run%0d cyc%0d: got %h expected %h", r, i, obs_w, exp_w);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [N-1:0] m;
      int hw, dly, gap, rep;
      m   = N'($urandom);
      hw  = $urandom_range(0, 3);
      dly = $urandom_range(0, 3);
      gap = $urandom_range(0, 3);
      rep = $urandom_range(1, 4);
      push_run(m, hw, dly, gap, rep);
      start_run(m, hw, dly, gap, rep);
      for (int i = 0; exp_q.size() > 0; i++) begin
        @(negedge clk);
        exp_w = exp_q.pop_front();
        obs_w = observe();
        n_vec++;
        if (obs_w !== exp_w) begin
          n_err++;
          $display("FAIL random run%0d cyc%0d: got %h expected %h", r, i, obs_w, exp_w);
        end
      end
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    model_cnt      = '0;
    rst            = 1'b1;
    bus.START      = 1'b0;
    bus.ABORT      = 1'b0;
    bus.PIX_MASK   = '0;
    bus.HIT_WIDTH  = '0;
    bus.TRIG_DELAY = '0;
    bus.GAP_LEN    = '0;
    bus.REPEAT     = '0;

    test_reset();
    test_basic();
    test_min_timing();
    test_repeat_zero();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_abort_start_same();
    test_mask_latch();
    test_back_to_back();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
